// File: rtl/puf_seq_pkg.sv
// Shared state encoding and default parameters for the PUF response sequencer.
package puf_seq_pkg;

  localparam int unsigned NBITS_DEF       = 8;
  localparam int unsigned SEL_W_DEF       = 4;
  localparam int unsigned SETTLE_CYC_DEF  = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 32'd1 << 24;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    RACE,
    DECIDE,
    DONE
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal arriving from another clock domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/puf_response_sequencer.sv
// Sequences ring-oscillator pair races and assembles one response bit per race, MSB first.
module puf_response_sequencer
  import puf_seq_pkg::*;
#(
  parameter int unsigned NBITS       = NBITS_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fin_a,
  input  logic             fin_b,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [NBITS-1:0] response,
  output logic             valid,
  output logic             busy,
  output logic             timeout_err,
  output logic             tie_seen
);

  localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ST_W  = $clog2(SETTLE_CYC + 1);

  logic fin_a_s;
  logic fin_b_s;

  sync_2ff u_sync_a (.clk(clk), .reset(reset), .d(fin_a), .q(fin_a_s));
  sync_2ff u_sync_b (.clk(clk), .reset(reset), .d(fin_b), .q(fin_b_s));

  state_e             state_q,      state_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic [ST_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
  logic               race_a_q,     race_a_d;
  logic               race_b_q,     race_b_d;
  logic [SEL_W-1:0]   sel_a_q,      sel_a_d;
  logic [SEL_W-1:0]   sel_b_q,      sel_b_d;
  logic               cnt_clear_q,  cnt_clear_d;
  logic               cnt_enable_q, cnt_enable_d;
  logic [NBITS-1:0]   response_q,   response_d;
  logic               valid_q,      valid_d;
  logic               busy_q,       busy_d;
  logic               to_err_q,     to_err_d;
  logic               tie_q,        tie_d;

  // Next-state and registered-output logic; outputs are derived from state_d so they align with the state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;
    race_a_d     = race_a_q;
    race_b_d     = race_b_q;
    sel_a_d      = sel_a_q;
    sel_b_d      = sel_b_q;
    response_d   = response_q;
    valid_d      = valid_q;
    to_err_d     = to_err_q;
    tie_d        = tie_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SELECT;
          idx_d      = '0;
          response_d = '0;
          valid_d    = 1'b0;
          to_err_d   = 1'b0;
          tie_d      = 1'b0;
        end
      end
      SELECT: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
      SETTLE: begin
        if (settle_cnt_q == ST_W'(SETTLE_CYC - 1)) begin
          state_d  = RACE;
          to_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + ST_W'(1);
        end
      end
      RACE: begin
        if (fin_a_s || fin_b_s) begin
          state_d  = DECIDE;
          race_a_d = fin_a_s;
          race_b_d = fin_b_s;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d  = DONE;
          to_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DECIDE: begin
        // A tie resolves to 0 and is flagged.
        response_d = NBITS'({response_q, race_a_q & ~race_b_q});
        if (race_a_q && race_b_q) begin
          tie_d = 1'b1;
        end
        if (idx_q == IDX_W'(NBITS - 1)) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SELECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == SELECT) begin
      sel_a_d = SEL_W'({idx_d, 1'b0});
      sel_b_d = SEL_W'({idx_d, 1'b1});
    end
    cnt_clear_d  = (state_d == SELECT);
    cnt_enable_d = (state_d == RACE);
    busy_d       = !(state_d inside {IDLE, DONE});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      race_a_q     <= 1'b0;
      race_b_q     <= 1'b0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      cnt_clear_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      response_q   <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      to_err_q     <= 1'b0;
      tie_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
      race_a_q     <= race_a_d;
      race_b_q     <= race_b_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      cnt_clear_q  <= cnt_clear_d;
      cnt_enable_q <= cnt_enable_d;
      response_q   <= response_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      to_err_q     <= to_err_d;
      tie_q        <= tie_d;
    end
  end

  assign sel_a       = sel_a_q;
  assign sel_b       = sel_b_q;
  assign cnt_clear   = cnt_clear_q;
  assign cnt_enable  = cnt_enable_q;
  assign response    = response_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign timeout_err = to_err_q;
  assign tie_seen    = tie_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Randomized and directed race scenarios for puf_response_sequencer against a per-bit outcome model.
module tb_puf_response_sequencer;

  localparam int unsigned NBITS       = 4;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned SETTLE_CYC  = 4;
  localparam int unsigned TIMEOUT_CYC = 64;

  localparam int ACT_A    = 0;
  localparam int ACT_B    = 1;
  localparam int ACT_TIE  = 2;
  localparam int ACT_NONE = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic             fin_a;
  logic             fin_b;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             cnt_clear;
  logic             cnt_enable;
  logic [NBITS-1:0] response;
  logic             valid;
  logic             busy;
  logic             timeout_err;
  logic             tie_seen;

  int n_checks = 0;
  int n_fail   = 0;
  int acts [NBITS];
  int dlys [NBITS];

  puf_response_sequencer #(
    .NBITS(NBITS), .SEL_W(SEL_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fin_a(fin_a), .fin_b(fin_b),
    .sel_a(sel_a), .sel_b(sel_b), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .response(response), .valid(valid), .busy(busy),
    .timeout_err(timeout_err), .tie_seen(tie_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sel_a, sel_b, cnt_clear, cnt_enable, response, valid, busy, timeout_err, tie_seen});
  endfunction

  // One run: fins are raised per acts/dlys; expected bits, flags and race lengths come from the plan.
  task automatic do_run(input int abort_bit, input bit poke_busy, input bit poke_done);
    int  exp_resp;
    bit  exp_tie;
    bit  exp_to;
    bit  aborted;
    int  n;
    exp_resp = 0;
    exp_tie  = 1'b0;
    exp_to   = 1'b0;
    aborted  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < int'(NBITS) && !exp_to && !aborted; b++) begin
      n = 0;
      while (!cnt_clear && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("clear_seen", 32'(cnt_clear), 1);
      chk("sel_a", 32'(sel_a), 32'(2 * b));
      chk("sel_b", 32'(sel_b), 32'(2 * b + 1));
      chk("busy_select", 32'(busy), 1);
      @(negedge clk);
      chk("clear_width", 32'(cnt_clear), 0);
      if (poke_busy && b == 1) start = 1'b1;
      n = 0;
      while (!cnt_enable && n < 100) begin
        @(negedge clk);
        start = 1'b0;
        n++;
      end
      chk("settle_len", 32'(n), SETTLE_CYC);
      n = 0;
      while (cnt_enable && n < 200) begin
        if (b == abort_bit && n == 5) begin
          reset = 1'b1;
          #1;
          chk("reset_outs", all_outs(), 0);
          aborted = 1'b1;
          break;
        end
        if (n == dlys[b] && acts[b] != ACT_NONE) begin
          fin_a = (acts[b] == ACT_A) || (acts[b] == ACT_TIE);
          fin_b = (acts[b] == ACT_B) || (acts[b] == ACT_TIE);
        end
        @(negedge clk);
        n++;
      end
      fin_a = 1'b0;
      fin_b = 1'b0;
      if (aborted) begin
        @(negedge clk);
        reset = 1'b0;
      end else if (acts[b] == ACT_NONE) begin
        exp_to = 1'b1;
        chk("race_timeout_len", 32'(n), TIMEOUT_CYC);
      end else begin
        // Two synchronizer stages plus the deciding edge after the fin edge.
        chk("race_len", 32'(n), 32'(dlys[b] + 3));
        exp_resp = (exp_resp * 2 + ((acts[b] == ACT_A) ? 1 : 0)) % (1 << NBITS);
        if (acts[b] == ACT_TIE) exp_tie = 1'b1;
      end
    end

    if (aborted) begin
      repeat (3) @(negedge clk);
      chk("abort_valid", 32'(valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_outs", all_outs(), 0);
    end else begin
      if (!exp_to) begin
        n = 0;
        while (!valid && n < 10) begin
          @(negedge clk);
          n++;
        end
        chk("valid", 32'(valid), 1);
        chk("response", 32'(response), 32'(exp_resp));
      end else begin
        chk("valid_on_timeout", 32'(valid), 0);
      end
      chk("busy_done", 32'(busy), 0);
      chk("timeout_err", 32'(timeout_err), 32'(exp_to));
      chk("tie_seen", 32'(tie_seen), 32'(exp_tie));
      if (poke_done) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", 32'(busy), 0);
        chk("done_start_valid", 32'(valid), 32'(!exp_to));
        @(negedge clk);
        chk("done_start_busy2", 32'(busy), 0);
        chk("done_start_clear", 32'(cnt_clear), 0);
      end
    end
  endtask

  task automatic rand_plan();
    int r;
    for (int b = 0; b < int'(NBITS); b++) begin
      r = int'($urandom_range(0, 7));
      acts[b] = (r <= 2 || r == 7) ? ACT_A : (r <= 5) ? ACT_B : ACT_TIE;
      dlys[b] = int'($urandom_range(0, 20));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fin_a = 1'b0;
    fin_b = 1'b0;
    #1;
    chk("reset_outs_init", all_outs(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    for (int b = 0; b < int'(NBITS); b++) begin acts[b] = ACT_A; dlys[b] = 10; end
    do_run(-1, 1'b0, 1'b0);

    for (int b = 0; b < int'(NBITS); b++) begin
      acts[b] = (b % 2 == 0) ? ACT_A : ACT_B;
      dlys[b] = 3 + b;
    end
    do_run(-1, 1'b0, 1'b1);

    acts = '{ACT_A, ACT_A, ACT_TIE, ACT_A};
    dlys = '{7, 2, 5, 0};
    do_run(-1, 1'b0, 1'b0);

    acts = '{ACT_B, ACT_NONE, ACT_A, ACT_A};
    dlys = '{4, 0, 4, 4};
    do_run(-1, 1'b0, 1'b1);

    acts = '{ACT_A, ACT_B, ACT_NONE, ACT_A};
    dlys = '{6, 6, 0, 6};
    do_run(2, 1'b0, 1'b0);

    rand_plan();
    do_run(-1, 1'b0, 1'b0);

    rand_plan();
    do_run(-1, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      rand_plan();
      do_run(-1, k[0], k[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
